// File: rtl/riot_bus_initiator.sv
// riot_bus_initiator: valid/ready host master for the 6532 RIOT register/RAM bus.
// Defining RIOT_DUMP_EN builds the save-state dump engine (RAM + DDRs + ports).
module riot_bus_initiator (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ce,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic       cmd_ram,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic [6:0] riot_addr,
   output logic       riot_rw_n,
   output logic       riot_rs_n,
   output logic       riot_cs1,
   output logic       riot_cs2_n,
   output logic [7:0] riot_wdata,
   input  logic [7:0] riot_rdata,
   input  logic       dump_start,
   output logic       dump_busy,
   output logic       dump_valid,
   output logic [7:0] dump_index,
   output logic [7:0] dump_data
);
`ifdef RIOT_DUMP_EN
   typedef enum logic [1:0] {IDLE, BUS, DUMP} state_t;
`else
   typedef enum logic [1:0] {IDLE, BUS} state_t;
`endif
   localparam logic [18:0] BUS_IDLE = {1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 8'd0};
   state_t     state, state_d;
   logic       cs1_d, cs2_n_d, rs_n_d, rw_n_d, rsp_valid_d;
   logic [6:0] addr_d;
   logic [7:0] wdata_d, rsp_data_d;
`ifdef RIOT_DUMP_EN
   logic       dump_valid_d;
   logic [7:0] dump_cnt, dump_cnt_d, dump_index_d, dump_data_d;
   // Bytes 128..131 map to DDRA, DDRB, port A, port B (addr 1, 3, 0, 2).
   function automatic logic [7:0] dump_map(input logic [7:0] k);
      return k[7] ? {1'b1, 5'd0, k[0], ~k[1]} : {1'b0, k[6:0]};
   endfunction
   assign cmd_ready = (state == IDLE) && !dump_start;
   assign dump_busy = (state == DUMP);
`else
   logic unused_dump_start;
   assign unused_dump_start = dump_start;
   assign cmd_ready  = (state == IDLE);
   assign dump_busy  = 1'b0;
   assign dump_valid = 1'b0;
   assign dump_index = 8'd0;
   assign dump_data  = 8'd0;
`endif
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state     <= IDLE;
         {riot_cs1, riot_cs2_n, riot_rs_n, riot_rw_n, riot_addr, riot_wdata} <= BUS_IDLE;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'd0;
      end else begin
         state      <= state_d;
         riot_cs1   <= cs1_d;
         riot_cs2_n <= cs2_n_d;
         riot_rs_n  <= rs_n_d;
         riot_rw_n  <= rw_n_d;
         riot_addr  <= addr_d;
         riot_wdata <= wdata_d;
         rsp_valid  <= rsp_valid_d;
         rsp_data   <= rsp_data_d;
      end
   end
`ifdef RIOT_DUMP_EN
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         dump_cnt   <= 8'd0;
         dump_valid <= 1'b0;
         dump_index <= 8'd0;
         dump_data  <= 8'd0;
      end else begin
         dump_cnt   <= dump_cnt_d;
         dump_valid <= dump_valid_d;
         dump_index <= dump_index_d;
         dump_data  <= dump_data_d;
      end
   end
`endif
   always_comb begin
      state_d     = state;
      cs1_d       = riot_cs1;
      cs2_n_d     = riot_cs2_n;
      rs_n_d      = riot_rs_n;
      rw_n_d      = riot_rw_n;
      addr_d      = riot_addr;
      wdata_d     = riot_wdata;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
`ifdef RIOT_DUMP_EN
      dump_cnt_d   = dump_cnt;
      dump_valid_d = 1'b0;
      dump_index_d = dump_index;
      dump_data_d  = dump_data;
`endif
      case (state)
         IDLE: begin
`ifdef RIOT_DUMP_EN
            if (dump_start) begin
               state_d    = DUMP;
               dump_cnt_d = 8'd0;
               {cs1_d, cs2_n_d, rs_n_d, rw_n_d, addr_d, wdata_d} = {1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 8'd0};
            end
`endif
            if (cmd_valid && cmd_ready) begin
               state_d = BUS;
               {cs1_d, cs2_n_d, rs_n_d, rw_n_d, addr_d, wdata_d} = {1'b1, 1'b0, ~cmd_ram, ~cmd_write, cmd_addr, cmd_wdata};
            end
         end
         BUS: if (ce) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = riot_rw_n ? riot_rdata : riot_wdata;
            {cs1_d, cs2_n_d, rs_n_d, rw_n_d, addr_d, wdata_d} = BUS_IDLE;
         end
`ifdef RIOT_DUMP_EN
         DUMP: if (ce) begin
            dump_valid_d = 1'b1;
            dump_index_d = dump_cnt;
            dump_data_d  = riot_rdata;
            if (dump_cnt == 8'd131) begin
               state_d = IDLE;
               {cs1_d, cs2_n_d, rs_n_d, rw_n_d, addr_d, wdata_d} = BUS_IDLE;
            end else begin
               dump_cnt_d       = dump_cnt + 8'd1;
               {rs_n_d, addr_d} = dump_map(dump_cnt + 8'd1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end
endmodule
